// File: rtl/serial_frame_deserializer.sv
// serial_frame_deserializer
// Collects DATA_W data bits, one command bit and an optional parity bit from
// a qualified serial stream and presents them as a parallel word with a
// one-cycle valid strobe. Aborted frames and parity failures are flagged.
module serial_frame_deserializer #(
   parameter int DATA_W     = 5,
   parameter int MSB_FIRST  = 1,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              data_val_i,
   input  logic              ser_data_i,
   output logic [DATA_W-1:0] data_o,
   output logic              command_o,
   output logic              valid_o,
   output logic              parity_err_o,
   output logic              frame_err_o,
   output logic              busy_o
);

   // Frame is data bits, command bit, then the optional parity bit.
   localparam int FRAME_LEN = DATA_W + 1 + ((PARITY_EN != 0) ? 1 : 0);
   localparam int CNT_W     = $clog2(FRAME_LEN + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FRAME_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic PAR_SENSE = (PARITY_ODD != 0);
   localparam logic PAR_ON    = (PARITY_EN != 0);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t                state_q, state_d;
   logic [FRAME_LEN-1:0]  shift_q, shift_d;
   logic [FRAME_LEN-1:0]  frame_full;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [DATA_W-1:0]     frame_data;
   logic [DATA_W-1:0]     data_d;
   logic                  command_d;
   logic                  valid_d;
   logic                  perr_d;
   logic                  ferr_d;
   logic                  complete;

   // The shift register with the current serial bit appended; on the final
   // bit this holds the whole frame with the first bit at the top.
   assign frame_full = {shift_q[FRAME_LEN-2:0], ser_data_i};

   assign busy_o = (state_q == SHIFT);

   // Re-order the data field so the first received bit lands per MSB_FIRST.
   always_comb begin
      frame_data = '0;
      for (int i = 0; i < DATA_W; i++) begin
         if (MSB_FIRST != 0) begin
            frame_data[i] = frame_full[FRAME_LEN-DATA_W+i];
         end else begin
            frame_data[i] = frame_full[FRAME_LEN-1-i];
         end
      end
   end

   // Next-state logic: collect bits, complete on the last one, abort on a gap.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      count_d   = count_q;
      data_d    = data_o;
      command_d = command_o;
      valid_d   = 1'b0;
      perr_d    = 1'b0;
      ferr_d    = 1'b0;
      complete  = 1'b0;

      case (state_q)
         IDLE: begin
            if (data_val_i) begin
               shift_d = frame_full;
               count_d = CNT_LOAD;
               if (FRAME_LEN == 1) begin
                  complete = 1'b1;
               end else begin
                  state_d = SHIFT;
               end
            end
         end
         SHIFT: begin
            if (data_val_i) begin
               shift_d = frame_full;
               count_d = count_q - CNT_ONE;
               if (count_q == CNT_ONE) begin
                  complete = 1'b1;
                  state_d  = IDLE;
               end
            end else begin
               state_d = IDLE;
               ferr_d  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (complete) begin
         data_d    = frame_data;
         command_d = frame_full[FRAME_LEN-1-DATA_W];
         valid_d   = 1'b1;
         perr_d    = PAR_ON && ((^frame_full) != PAR_SENSE);
      end
   end

   // State, datapath and registered outputs; async reset clears everything.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         shift_q      <= '0;
         count_q      <= '0;
         data_o       <= '0;
         command_o    <= 1'b0;
         valid_o      <= 1'b0;
         parity_err_o <= 1'b0;
         frame_err_o  <= 1'b0;
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         count_q      <= count_d;
         data_o       <= data_d;
         command_o    <= command_d;
         valid_o      <= valid_d;
         parity_err_o <= perr_d;
         frame_err_o  <= ferr_d;
      end
   end

endmodule

// File: doc/serial_frame_deserializer.md
# serial_frame_deserializer

Parametrised serial-to-parallel frame receiver for the command/data link. It collects a frame of DATA_W data bits, one command bit and an optional parity bit from a one-bit serial stream qualified by data_val_i. It presents the frame as a parallel word with a single-cycle valid strobe, and flags aborted frames and parity failures. It sits between the serial link front end and the command decoder, and supports zero-gap back-to-back frames.

## Interface
- DATA_W, default 5: data bits per frame; legal range 1..32.
- MSB_FIRST, default 1: 1 means the first received data bit lands in data_o[DATA_W-1]; 0 means it lands in data_o[0].
- PARITY_EN, default 0: 1 appends one parity bit after the command bit.
- PARITY_ODD, default 0: parity sense when PARITY_EN=1. 0 is even parity, 1 is odd parity, computed over the data bits, the command bit and the parity bit.
- Clocking and reset are decided: one clock, reset asynchronous and active-low.
- clk_i, input, 1: sole clock; all logic on its rising edge.
- rst_ni, input, 1: asynchronous active-low reset.
- data_val_i, input, 1: qualifies ser_data_i; must stay high for every bit of a frame.
- ser_data_i, input, 1: serial bit, sampled only when data_val_i=1.
- data_o, output, DATA_W: last good-framed data word; held between frames.
- command_o, output, 1: command bit of the last good-framed frame; held.
- valid_o, output, 1: one-cycle pulse when data_o and command_o update.
- parity_err_o, output, 1: one-cycle pulse coincident with valid_o on parity mismatch; always 0 when PARITY_EN=0.
- frame_err_o, output, 1: one-cycle pulse when a frame is aborted.
- busy_o, output, 1: high while in SHIFT.

## Operation
- Frame length L = DATA_W + 1 + PARITY_EN bits, in order: data bits, then the command bit, then the parity bit if enabled.
- FSM states:
  - IDLE: waits for data_val_i=1, then samples bit 0 into the shift register, loads count with L-1 and goes to SHIFT. If L=1 is ever reached, the frame completes immediately.
  - SHIFT: each cycle with data_val_i=1 samples the next bit and decrements count.
  - On the edge that samples the final bit (count=1), the FSM completes the frame and returns to IDLE.
- Frame completion, on the same edge:
  - data_o is loaded from the shift register, bit-ordered per MSB_FIRST.
  - command_o is loaded from the command bit.
  - valid_o=1 for the next cycle.
  - parity_err_o=1 if PARITY_EN=1 and the parity check fails.
  - Data is delivered even when parity_err_o=1.
- Abort: data_val_i=0 in SHIFT sends the FSM to IDLE and pulses frame_err_o=1 for one cycle. Partial data is discarded; data_o, command_o and valid_o are not updated.
- Back-to-back frames: data_val_i held high across a frame boundary starts the next frame on the cycle after the final bit. There is no gap and no bit is lost.
- In IDLE with data_val_i=0, the shift register and count hold. Outputs hold except the pulse outputs, which are 0.
- Count width is $clog2(L+1); no wrap is possible within a frame.
- Parity calculation is an XOR reduction over the data bits, the command bit and the parity bit. The frame passes when the result equals PARITY_ODD.

## Timing
- Reset (rst_ni=0, async): FSM=IDLE, count=0, shift register=0, data_o=0, command_o=0, valid_o=0, parity_err_o=0, frame_err_o=0, busy_o=0.
- Reset release takes effect at the first rising edge with rst_ni=1.
- Cycle numbering: cycle 0 is the first cycle with data_val_i=1 in IDLE.
  - Bit k is sampled at the edge ending cycle k.
  - valid_o, data_o and command_o update after the edge ending cycle L-1, so they are visible in cycle L.
  - Latency is L cycles from the first bit to the strobe.
- busy_o is high in cycles 1..L-1.
- frame_err_o is high in the cycle after the edge that sees data_val_i=0 in SHIFT.
- Reset asserted mid-frame discards the frame immediately. There is no valid_o or frame_err_o pulse.
- Pulse outputs never stay high for two consecutive cycles from a single frame. Sustained streaming gives one valid_o every L cycles.

## Test plan
- Default parameters, MSB_FIRST=1: stream 1,0,1,1,0 then command 1, data_val_i high for 6 cycles. Required: data_o=5'b10110, command_o=1, valid_o pulse in cycle 6 only, busy_o high in cycles 1..5.
- MSB_FIRST=0, same stream. Required: data_o=5'b01101, command_o=1, strobe timing as above.
- PARITY_EN=1, PARITY_ODD=0, DATA_W=5: frame 1,1,0,0,0 with command 1 and parity 1. Required: valid_o with parity_err_o=0. Same frame with parity 0: valid_o with parity_err_o=1, data_o=5'b11000 still delivered.
- Abort: drop data_val_i after 3 bits. Required: frame_err_o pulse in the next cycle, no valid_o, data_o and command_o unchanged. A new frame starting 1 cycle later decodes correctly.
- Back-to-back: 3 frames, data_val_i high for 18 consecutive cycles. Required: valid_o in cycles 6, 12 and 18 with the correct word each time, and no frame_err_o.
- Reset mid-frame: rst_ni low at cycle 3 of a frame. Required: all outputs 0 immediately, no strobes. A frame after release decodes with the L-cycle latency.
